// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NB_REQ requesters.
// Registers the winning command onto the port and routes each read response back to its issuer.
module bram_arbiter #(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NB_REQ-1:0]                     req_valid,
  output logic [NB_REQ-1:0]                     req_ready,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]     req_wr_data,
  input  logic [NB_REQ-1:0]                     req_wr_en,
  input  logic [NB_REQ-1:0]                     req_rd_en,
  output logic [NB_REQ-1:0]                     rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [ADDR_WIDTH-1:0]                 bram_addr,
  output logic [DATA_WIDTH-1:0]                 bram_wr_data,
  output logic                                  bram_wr_en,
  output logic                                  bram_rd_en,
  input  logic [DATA_WIDTH-1:0]                 bram_rd_data
);

  localparam int ID_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic                               grant_vld;
  logic [ID_W-1:0]                    grant_id;
  logic                               accept;

  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]              wr_data_q, wr_data_d;
  logic                               wr_en_q, wr_en_d;
  logic                               rd_en_q, rd_en_d;
  logic [ID_W-1:0]                    id_q, id_d;

  logic [RD_LATENCY-1:0]              tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][ID_W-1:0]    tag_id_q, tag_id_d;

  logic [NB_REQ-1:0]                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]              rsp_data_q, rsp_data_d;

  // Lowest index at or above ptr wins; otherwise lowest index below ptr (wrap-around).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int j = NB_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) < ptr_q)) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(j);
      end
    end
    for (int j = NB_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) >= ptr_q)) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(j);
      end
    end
  end

  assign accept = grant_vld && !rst;

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    id_d      = id_q;
    if (accept) begin
      ptr_d = (grant_id == ID_W'(NB_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      id_d  = grant_id;
      for (int j = 0; j < NB_REQ; j++) begin
        if (grant_id == ID_W'(j)) begin
          addr_d    = req_addr[j];
          wr_data_d = req_wr_data[j];
          wr_en_d   = req_wr_en[j];
          rd_en_d   = req_rd_en[j];
        end
      end
    end
  end

  // Tag stage s is valid in the cycle s+1 after the read leaves the issue register.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = rd_en_q;
    tag_id_d[0]  = id_q;
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_rsp
      assign rsp_valid_d[gi] = tag_vld_q[RD_LATENCY-1] &&
                               (tag_id_q[RD_LATENCY-1] == ID_W'(gi));
    end
  endgenerate

  assign rsp_data_d = tag_vld_q[RD_LATENCY-1] ? bram_rd_data : rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      id_q        <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      id_q        <= id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bram_addr    = addr_q;
  assign bram_wr_data = wr_data_q;
  assign bram_wr_en   = wr_en_q;
  assign bram_rd_en   = rd_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; includes a read-first BRAM model on the port.
module tb_bram_arbiter;
  localparam int NB_REQ = 2;
  localparam int AW     = 16;
  localparam int DW     = 512;
  localparam int RL     = 3;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NB_REQ-1:0]         req_valid = '0;
  logic [NB_REQ-1:0]         req_ready;
  logic [NB_REQ-1:0][AW-1:0] req_addr = '0;
  logic [NB_REQ-1:0][DW-1:0] req_wr_data = '0;
  logic [NB_REQ-1:0]         req_wr_en = '0;
  logic [NB_REQ-1:0]         req_rd_en = '0;
  logic [NB_REQ-1:0]         rsp_valid;
  logic [DW-1:0]             rsp_data;
  logic [AW-1:0]             bram_addr;
  logic [DW-1:0]             bram_wr_data;
  logic                      bram_wr_en;
  logic                      bram_rd_en;
  logic [DW-1:0]             bram_rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.NB_REQ(NB_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_wr_en(req_wr_en), .req_rd_en(req_rd_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data),
    .bram_wr_en(bram_wr_en), .bram_rd_en(bram_rd_en),
    .bram_rd_data(bram_rd_data)
  );

  // Power-up memory content: low word 0x1224+addr, so address 0x10 reads 0x1234.
  function automatic logic [DW-1:0] init_word(int a);
    logic [DW-1:0] w;
    w = '0;
    w[31:0] = 32'h1224 + 32'(a);
    return w;
  endfunction

  // BRAM model: read-first, RL-cycle read pipeline; stored as XOR-delta to the init pattern.
  bit   [DW-1:0] xmem [256];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (bram_wr_en) xmem[bram_addr[7:0]] <= bram_wr_data ^ init_word(int'(bram_addr[7:0]));
    rd_pipe[0] <= bram_rd_en ? (xmem[bram_addr[7:0]] ^ init_word(int'(bram_addr[7:0])))
                             : {(DW/32){32'hDEADBEEF}};
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bram_rd_data = rd_pipe[RL-1];

  // Reference memory: value seen by a read = result of all writes accepted before it.
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] ref_read(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0; req_rd_en = '0; req_wr_en = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11; req_rd_en = 2'b11;
    tick(); tick(); tick();
    #1;
    tests++;
    if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    tests++;
    if (rsp_valid !== 2'b00 || bram_wr_en !== 1'b0 || bram_rd_en !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: got rsp_valid=%b wr=%b rd=%b expected 00/0/0", rsp_valid, bram_wr_en, bram_rd_en);
    end
    tests++;
    if (bram_addr !== '0 || bram_wr_data !== '0 || rsp_data !== '0) begin
      fails++; $display("FAIL reset_data: got addr=%h wdata_low=%h rsp_low=%h expected zeros", bram_addr, bram_wr_data[31:0], rsp_data[31:0]);
    end
    $display("[TB] reset checked");
    req_valid = '0; req_rd_en = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [NB_REQ-1:0] exp_rv;
    tick();
    req_valid = 2'b01; req_rd_en = 2'b01; req_wr_en = 2'b00; req_addr[0] = 16'h0010;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin req_valid = '0; req_rd_en = '0; end
      #1;
      if (k == 1) begin
        tests++;
        if (bram_rd_en !== 1'b1 || bram_wr_en !== 1'b0 || bram_addr !== 16'h0010) begin
          fails++; $display("FAIL rd_issue: got rd=%b wr=%b addr=%h expected 1/0/0010", bram_rd_en, bram_wr_en, bram_addr);
        end
      end
      exp_rv = (k == 5) ? 2'b01 : 2'b00;
      tests++;
      if (rsp_valid !== exp_rv) begin fails++; $display("FAIL rd_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_rv); end
      if (k == 5) begin
        tests++;
        if (rsp_data !== init_word(16)) begin fails++; $display("FAIL rd_rsp_data: got %h expected 1234", rsp_data[31:0]); end
      end
    end
    $display("[TB] single read addr 0010 checked");
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d;
    d = {(DW/32){32'hA5A5A5A5}};
    tick();
    req_valid = 2'b01; req_wr_en = 2'b01; req_rd_en = 2'b00; req_addr[0] = 16'h0010; req_wr_data[0] = d;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin fails++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
    ref_mem[16] = d;
    tick();
    req_valid = '0; req_wr_en = '0;
    #1;
    tests++;
    if (bram_wr_en !== 1'b1 || bram_rd_en !== 1'b0 || bram_addr !== 16'h0010 || bram_wr_data !== d) begin
      fails++; $display("FAIL wr_issue: got wr=%b rd=%b addr=%h expected 1/0/0010 with A5 data", bram_wr_en, bram_rd_en, bram_addr);
    end
    tick();
    #1;
    tests++;
    if (bram_wr_en !== 1'b0 || bram_addr !== 16'h0010) begin
      fails++; $display("FAIL wr_idle_hold: got wr=%b addr=%h expected 0/0010", bram_wr_en, bram_addr);
    end
    $display("[TB] single write addr 0010 checked");
  endtask

  task automatic test_contention();
    logic [NB_REQ-1:0] exp_r;
    logic [DW-1:0]     exp_d;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k < 6) begin
        req_valid = 2'b11; req_rd_en = 2'b11; req_wr_en = 2'b00;
        req_addr[0] = 16'h0001; req_addr[1] = 16'h0002;
      end else begin
        req_valid = '0; req_rd_en = '0;
      end
      #1;
      if (k < 6) begin
        exp_r = (k % 2 == 0) ? 2'b01 : 2'b10;
        tests++;
        if (req_ready !== exp_r) begin fails++; $display("FAIL cont_grant k=%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      if (k >= 5 && k <= 10) begin
        exp_r = ((k - 5) % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = ref_read(((k - 5) % 2 == 0) ? 1 : 2);
        tests++;
        if (rsp_valid !== exp_r || rsp_data !== exp_d) begin
          fails++; $display("FAIL cont_rsp k=%0d: got %b/%h expected %b/%h", k, rsp_valid, rsp_data[31:0], exp_r, exp_d[31:0]);
        end
      end else begin
        tests++;
        if (rsp_valid !== 2'b00) begin fails++; $display("FAIL cont_rsp_idle k=%0d: got %b expected 00", k, rsp_valid); end
      end
    end
    $display("[TB] contention alternation checked");
  endtask

  task automatic test_pointer_fairness();
    logic [NB_REQ-1:0] exp_r;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      req_rd_en = '0; req_wr_en = '0;
      if (k < 3) begin req_valid = 2'b10; req_addr[1] = AW'(k); end
      else if (k == 3) req_valid = 2'b11;
      else if (k == 4) req_valid = 2'b10;
      else req_valid = '0;
      #1;
      if (k < 5) begin
        exp_r = (k == 3) ? 2'b01 : 2'b10;
        tests++;
        if (req_ready !== exp_r) begin fails++; $display("FAIL ptr_grant k=%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      if (k >= 1) begin
        tests++;
        if (bram_rd_en !== 1'b0 || bram_wr_en !== 1'b0 || rsp_valid !== 2'b00) begin
          fails++; $display("FAIL noop_issue k=%0d: got rd=%b wr=%b rsp=%b expected 0/0/00", k, bram_rd_en, bram_wr_en, rsp_valid);
        end
      end
      if (k == 2) begin
        tests++;
        if (bram_addr !== 16'h0001) begin fails++; $display("FAIL noop_addr: got %h expected 0001", bram_addr); end
      end
    end
    $display("[TB] pointer fairness and no-op checked");
  endtask

  task automatic test_mixed_traffic();
    logic [DW-1:0]     d;
    logic [NB_REQ-1:0] exp_r;
    d = '0; d[15:0] = 16'hBEEF;
    for (int k = 0; k < 9; k++) begin
      tick();
      req_valid = '0; req_rd_en = '0; req_wr_en = '0;
      if (k == 0) begin req_valid = 2'b01; req_wr_en = 2'b01; req_addr[0] = 16'h0005; req_wr_data[0] = d; end
      if (k == 1) begin req_valid = 2'b10; req_rd_en = 2'b10; req_addr[1] = 16'h0005; end
      #1;
      if (k == 0 || k == 1) begin
        exp_r = (k == 0) ? 2'b01 : 2'b10;
        tests++;
        if (req_ready !== exp_r) begin fails++; $display("FAIL mix_grant k=%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      if (k == 1) begin
        tests++;
        if (bram_wr_en !== 1'b1 || bram_rd_en !== 1'b0 || bram_addr !== 16'h0005 || bram_wr_data !== d) begin
          fails++; $display("FAIL mix_wr_issue: got wr=%b rd=%b addr=%h expected 1/0/0005", bram_wr_en, bram_rd_en, bram_addr);
        end
      end
      if (k == 2) begin
        tests++;
        if (bram_wr_en !== 1'b0 || bram_rd_en !== 1'b1 || bram_addr !== 16'h0005) begin
          fails++; $display("FAIL mix_rd_issue: got wr=%b rd=%b addr=%h expected 0/1/0005", bram_wr_en, bram_rd_en, bram_addr);
        end
      end
      if (k >= 1) begin
        exp_r = (k == 6) ? 2'b10 : 2'b00;
        tests++;
        if (rsp_valid !== exp_r) begin fails++; $display("FAIL mix_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_r); end
        if (k == 6) begin
          tests++;
          if (rsp_data !== d) begin fails++; $display("FAIL mix_rsp_data: got %h expected beef", rsp_data[31:0]); end
        end
      end
    end
    ref_mem[5] = d;
    $display("[TB] write-then-read ordering checked");
  endtask

  task automatic test_reset_midflight();
    logic [NB_REQ-1:0] exp_r;
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      tick();
      rst = 1'b0;
      req_valid = '0; req_rd_en = '0; req_wr_en = '0;
      case (k)
        0: begin req_valid = 2'b10; req_rd_en = 2'b10; req_addr[1] = 16'h0002; end
        1: begin req_valid = 2'b01; req_rd_en = 2'b01; req_addr[0] = 16'h0001; end
        2: rst = 1'b1;
        3: begin req_valid = 2'b11; req_rd_en = 2'b01; req_addr[0] = 16'h0003; end
        4: req_valid = 2'b10;
        default: ;
      endcase
      #1;
      if (k == 0 || k == 1 || k == 2 || k == 3 || k == 4) begin
        exp_r = (k == 0 || k == 4) ? 2'b10 : (k == 2) ? 2'b00 : 2'b01;
        tests++;
        if (req_ready !== exp_r) begin fails++; $display("FAIL rstmid_grant k=%0d: got %b expected %b", k, req_ready, exp_r); end
      end
      if (k == 2) begin
        tests++;
        if (bram_rd_en !== 1'b1 || bram_addr !== 16'h0001) begin
          fails++; $display("FAIL rstmid_issue: got rd=%b addr=%h expected 1/0001", bram_rd_en, bram_addr);
        end
      end
      if (k == 3) begin
        tests++;
        if (bram_addr !== '0 || bram_wr_data !== '0 || bram_rd_en !== 1'b0 || bram_wr_en !== 1'b0 || rsp_data !== '0) begin
          fails++; $display("FAIL rstmid_outputs: got addr=%h rd=%b wr=%b expected reset values", bram_addr, bram_rd_en, bram_wr_en);
        end
      end
      exp_r = (k == 8) ? 2'b01 : 2'b00;
      tests++;
      if (rsp_valid !== exp_r) begin fails++; $display("FAIL rstmid_rsp k=%0d: got %b expected %b", k, rsp_valid, exp_r); end
      if (k == 8) begin
        tests++;
        if (rsp_data !== ref_read(3)) begin fails++; $display("FAIL rstmid_rsp_data: got %h expected %h", rsp_data[31:0], ref_read(3) & 32'hFFFFFFFF); end
      end
    end
    $display("[TB] reset mid-flight checked");
  endtask

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_rsp_t;

  task automatic test_random_traffic();
    exp_rsp_t          rq[$];
    exp_rsp_t          e;
    logic              pv [NB_REQ];
    logic              prd[NB_REQ];
    logic              pwr[NB_REQ];
    int                pa [NB_REQ];
    logic [DW-1:0]     pd [NB_REQ];
    int                mptr, w, j;
    logic [NB_REQ-1:0] exp_r, exp_v;
    logic              exp_wr, exp_rd;
    logic [AW-1:0]     exp_addr;
    logic [DW-1:0]     exp_data, last_rsp;
    int                nerr;
    apply_reset();
    mptr = 0; exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_data = '0; last_rsp = '0; nerr = 0;
    for (int i = 0; i < NB_REQ; i++) begin pv[i] = 0; prd[i] = 0; pwr[i] = 0; pa[i] = 0; pd[i] = '0; end
    for (int cur = 0; cur < 408; cur++) begin
      tick();
      for (int i = 0; i < NB_REQ; i++) begin
        if (!pv[i] && cur < 400 && $urandom_range(0, 3) != 0) begin
          pv[i] = 1; pa[i] = $urandom_range(0, 7); pd[i] = rand_data();
          {prd[i], pwr[i]} = 2'($urandom_range(0, 3));
        end
        req_valid[i] = pv[i]; req_rd_en[i] = prd[i]; req_wr_en[i] = pwr[i];
        req_addr[i] = AW'(pa[i]); req_wr_data[i] = pd[i];
      end
      #1;
      w = -1;
      for (int k = 0; k < NB_REQ; k++) begin
        j = (mptr + k) % NB_REQ;
        if (pv[j] && w < 0) w = j;
      end
      exp_r = '0;
      if (w >= 0) exp_r[w] = 1'b1;
      tests++;
      if (req_ready !== exp_r) begin fails++; nerr++; $display("FAIL rnd_grant cyc=%0d: got %b expected %b", cur, req_ready, exp_r); end
      tests++;
      if (bram_wr_en !== exp_wr || bram_rd_en !== exp_rd || bram_addr !== exp_addr || bram_wr_data !== exp_data) begin
        fails++; nerr++;
        $display("FAIL rnd_issue cyc=%0d: got wr=%b rd=%b addr=%h expected wr=%b rd=%b addr=%h", cur, bram_wr_en, bram_rd_en, bram_addr, exp_wr, exp_rd, exp_addr);
      end
      exp_v = '0;
      if (rq.size() > 0 && rq[0].due == cur) begin
        e = rq.pop_front();
        exp_v[e.id] = 1'b1;
        last_rsp = e.data;
      end
      tests++;
      if (rsp_valid !== exp_v || rsp_data !== last_rsp) begin
        fails++; nerr++;
        $display("FAIL rnd_rsp cyc=%0d: got %b/%h expected %b/%h", cur, rsp_valid, rsp_data[31:0], exp_v, last_rsp[31:0]);
      end
      if (w >= 0) begin
        exp_wr = pwr[w]; exp_rd = prd[w]; exp_addr = AW'(pa[w]); exp_data = pd[w];
        if (prd[w]) begin
          e.due = cur + 1 + RL + 1; e.id = w; e.data = ref_read(pa[w]);
          rq.push_back(e);
        end
        if (pwr[w]) ref_mem[pa[w]] = pd[w];
        mptr = (w + 1) % NB_REQ;
        pv[w] = 0;
      end else begin
        exp_wr = 0; exp_rd = 0;
      end
    end
    tests++;
    if (rq.size() != 0) begin fails++; $display("FAIL rnd_drain: got %0d pending responses expected 0", rq.size()); end
    req_valid = '0; req_rd_en = '0; req_wr_en = '0;
    $display("[TB] random traffic: 408 cycles, %0d mismatching cycles", nerr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_pointer_fairness();
    test_mixed_traffic();
    test_reset_midflight();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
